// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: zeroes all registers after reset or
// on request, then arbitrates two writeback requesters onto one registered write port.
module regfile_write_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear_req,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              r_rr_last;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              w_grant0;
  logic              w_grant1;

  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    // A clear request restarts the sweep from register 0 in the same cycle.
    w_clr_idx   = i_clear_req ? '0 : r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (w_clr_idx == LP_LAST_IDX) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (i_clear_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (!i_rst) begin
          if (i_req0_valid && i_req1_valid) begin
            if (FIXED_PRIO || r_rr_last) w_grant0 = 1'b1;
            else                         w_grant1 = 1'b1;
          end else if (i_req0_valid) begin
            w_grant0 = 1'b1;
          end else if (i_req1_valid) begin
            w_grant1 = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_rr_last <= 1'b1;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_clr_idx;
          r_wr_data <= '0;
          r_clr_cnt <= w_clr_idx + 1'b1;
          r_busy    <= (w_clr_idx != LP_LAST_IDX);
        end
        ST_ARB: begin
          r_wr_en <= 1'b0;
          if (i_clear_req) begin
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end else if (w_grant0) begin
            r_wr_addr <= i_req0_addr;
            r_wr_data <= i_req0_data;
            r_wr_en   <= (i_req0_addr != '0);
            r_rr_last <= 1'b0;
          end else if (w_grant1) begin
            r_wr_addr <= i_req1_addr;
            r_wr_data <= i_req1_data;
            r_wr_en   <= (i_req1_addr != '0);
            r_rr_last <= 1'b1;
          end
        end
        default: begin
          r_wr_en <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sweep, single writes, round-robin
// alternation, r0 suppression, clear_req from ARB and reset in mid-sweep.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(
    .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .FIXED_PRIO(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_clear_req(clear_req),
    .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_data(req0_data),
    .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_data(req1_data),
    .o_req1_ready(req1_ready),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_req = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
    tick();
    tick();
    n_vec++;
    if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    n_vec++;
    if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
    n_vec++;
    if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b exp 1", busy); end
    n_vec++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
    end
  endtask

  task automatic run_clear_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'd0) begin
        n_err++;
        $display("FAIL %s_write%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=0",
                 tag, i, wr_en, wr_addr, wr_data, i);
      end
      n_vec++;
      if (busy !== (i != 31)) begin
        n_err++; $display("FAIL %s_busy%0d got %b exp %b", tag, i, busy, (i != 31));
      end
      if (i != 31) begin
        n_vec++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_err++; $display("FAIL %s_ready%0d got %b%b exp 00", tag, i, req0_ready, req1_ready);
        end
      end
    end
  endtask

  task automatic test_clear_after_reset();
    rst = 1'b0;
    run_clear_sweep("t1");
    // Now in ARB with both requesters still asserting; the first tie goes to req0.
    n_vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL t1_first_tie got %b%b exp 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_vec++;
    if (wr_en !== 1'b0) begin n_err++; $display("FAIL t1_idle_wr_en got %b exp 0", wr_en); end
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5A5_0001;
    #1;
    n_vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL t2_ready got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL t2_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=a5a50001",
                        wr_en, wr_addr, wr_data);
    end
    tick();
    n_vec++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL t2_hold got en=%b addr=%0d data=%h exp en=0 addr=5 data=a5a50001",
                        wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_r0_write();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    #1;
    n_vec++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL t4_ready got %b%b exp 01", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_vec++;
    if (wr_en !== 1'b0) begin n_err++; $display("FAIL t4_r0_strobe got %b exp 0", wr_en); end
    n_vec++;
    if (wr_addr !== 5'd0 || wr_data !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL t4_r0_data got addr=%0d data=%h exp addr=0 data=ffffffff", wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic       exp0;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0033;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0044;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      exp_addr = exp0 ? 5'd3 : 5'd4;
      exp_data = exp0 ? 32'h33 : 32'h44;
      #1;
      n_vec++;
      if (req0_ready !== exp0 || req1_ready !== !exp0) begin
        n_err++; $display("FAIL t3_grant%0d got %b%b exp %b%b", i, req0_ready, req1_ready, exp0, !exp0);
      end
      tick();
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== exp_data) begin
        n_err++; $display("FAIL t3_write%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                          i, wr_en, wr_addr, wr_data, exp_addr, exp_data);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_clear_req();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    clear_req = 1'b1;
    #1;
    n_vec++;
    if (req0_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready_on_clear got %b exp 0", req0_ready); end
    tick();
    clear_req = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL t5_enter_clear got busy=%b en=%b exp busy=1 en=0", busy, wr_en);
    end
    run_clear_sweep("t5");
    n_vec++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL t5_regrant got %b exp 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h77) begin
      n_err++; $display("FAIL t5_write got en=%b addr=%0d data=%h exp en=1 addr=7 data=77",
                        wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (wr_addr !== 5'd9 || wr_en !== 1'b1) begin
      n_err++; $display("FAIL t6_pre_reset got en=%b addr=%0d exp en=1 addr=9", wr_en, wr_addr);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL t6_reset got en=%b busy=%b exp en=0 busy=1", wr_en, busy);
    end
    rst = 1'b0;
    run_clear_sweep("t6");
    // Reset during ARB must block a same-cycle request.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    rst = 1'b1;
    #1;
    n_vec++;
    if (req0_ready !== 1'b0) begin n_err++; $display("FAIL t6_rst_ready got %b exp 0", req0_ready); end
    tick();
    req0_valid = 1'b0;
    rst = 1'b0;
    n_vec++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL t6_rst_hs got en=%b addr=%0d busy=%b exp en=0 addr=0 busy=1",
                        wr_en, wr_addr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clear_after_reset();
    test_single_write();
    test_r0_write();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
